source_scanner: RTL and testbench

Sequencing controller for the two-stage DDR signal-source MUX in the capture path.
- Drives the MUX enable and select, stepping through a programmed antenna range (scan mode) or holding one source (fixed mode).
- Inserts guard cycles after each source switch and dwells a programmed number of samples per source.
- Tags every MUX output sample with its source index and a keep strobe, so downstream clock-recovery and capture logic only consumes settled samples.

---
 rtl/source_scanner_if.sv | 41 ++++
 rtl/source_scanner.sv | 162 ++++++++++++++++
 tb/tb_source_scanner.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/source_scanner_if.sv
// source_scanner_if: control, MUX-side and status signals of the source scanner.
//   slave  modport: used by source_scanner (consumes start/config/mux_valid, drives the rest)
//   master modport: used by the controlling agent
// Signals:
//   start_i, abort_i, mode_i, cont_i        run control and mode
//   fixed_i, first_i, last_i, dwell_i       source selection and dwell configuration
//   mux_valid_i                             MUX output valid
//   mux_enable_o, mux_select_o              MUX drive
//   strobe_o, tag_o                         keep strobe and source tag of the current MUX sample
//   busy_o, done_o, cfg_err_o               status
interface source_scanner_if #(
    parameter int unsigned SBITS = 5,
    parameter int unsigned CBITS = 8
);
    logic             start_i;
    logic             abort_i;
    logic             mode_i;
    logic             cont_i;
    logic [SBITS-1:0] fixed_i;
    logic [SBITS-1:0] first_i;
    logic [SBITS-1:0] last_i;
    logic [CBITS-1:0] dwell_i;
    logic             mux_valid_i;
    logic             mux_enable_o;
    logic [SBITS-1:0] mux_select_o;
    logic             strobe_o;
    logic [SBITS-1:0] tag_o;
    logic             busy_o;
    logic             done_o;
    logic             cfg_err_o;

    modport master (
        output start_i, abort_i, mode_i, cont_i, fixed_i, first_i, last_i, dwell_i, mux_valid_i,
        input  mux_enable_o, mux_select_o, strobe_o, tag_o, busy_o, done_o, cfg_err_o
    );

    modport slave (
        input  start_i, abort_i, mode_i, cont_i, fixed_i, first_i, last_i, dwell_i, mux_valid_i,
        output mux_enable_o, mux_select_o, strobe_o, tag_o, busy_o, done_o, cfg_err_o
    );
endinterface

// File: rtl/source_scanner.sv
// source_scanner: sequences the signal-source MUX through a scan range or holds a fixed
// source, inserts guard cycles after every select change, dwells a programmed number of
// samples per source and tags each MUX output sample with its source and a keep strobe.
// Ports:
//   clock_i  sampling-domain clock
//   reset_i  asynchronous active-high reset
//   bus      source_scanner_if.slave (control, configuration, MUX drive, tags, status)
module source_scanner #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned SBITS   = 5,
    parameter int unsigned CBITS   = 8,
    parameter int unsigned GUARD   = 2,
    parameter int unsigned LATENCY = 2
) (
    input logic            clock_i,
    input logic            reset_i,
    source_scanner_if.slave bus
);
    localparam int unsigned      GBITS    = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GBITS-1:0] GuardLoad = GBITS'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [SBITS-1:0] MaxIdx    = SBITS'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StGuard, StDwell} state_e;

    // State entered after any select change; with no guard the dwell starts at once.
    localparam state_e StSwitch = (GUARD == 0) ? StDwell : StGuard;

    state_e           state_q, state_d;
    logic [SBITS-1:0] sel_q, sel_d;
    logic [GBITS-1:0] guard_cnt_q, guard_cnt_d;
    logic [CBITS-1:0] dwell_cnt_q, dwell_cnt_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             mode_q, mode_d;
    logic             cont_q, cont_d;
    logic [SBITS-1:0] first_q, first_d;
    logic [SBITS-1:0] last_q, last_d;
    logic [CBITS-1:0] dwell_q, dwell_d;
    logic             cfg_ok;
    logic             abort_go;

    // Keep/tag delay line matching the MUX select-to-output latency; index LATENCY-1 is the tail.
    logic [LATENCY-1:0]            keep_q;
    logic [LATENCY-1:0][SBITS-1:0] tag_q;

    assign abort_go = bus.abort_i && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        guard_cnt_d = GuardLoad;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        mode_d      = mode_q;
        cont_d      = cont_q;
        first_d     = first_q;
        last_d      = last_q;
        dwell_d     = dwell_q;
        cfg_ok      = bus.mode_i ? ((bus.first_i <= bus.last_i) && (bus.last_i <= MaxIdx))
                                 : (bus.fixed_i <= MaxIdx);
        unique case (state_q)
            StIdle: begin
                // Abort in the same cycle suppresses the start.
                if (bus.start_i && !bus.abort_i) begin
                    if (cfg_ok) begin
                        cfg_err_d   = 1'b0;
                        mode_d      = bus.mode_i;
                        cont_d      = bus.cont_i;
                        first_d     = bus.first_i;
                        last_d      = bus.last_i;
                        dwell_d     = bus.dwell_i;
                        dwell_cnt_d = bus.dwell_i;
                        sel_d       = bus.mode_i ? bus.first_i : bus.fixed_i;
                        state_d     = StSwitch;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StGuard: begin
                dwell_cnt_d = dwell_q;
                if (bus.abort_i) begin
                    state_d = StIdle;
                end else if (guard_cnt_q == '0) begin
                    state_d = StDwell;
                end else begin
                    guard_cnt_d = guard_cnt_q - 1'b1;
                end
            end
            StDwell: begin
                if (bus.abort_i) begin
                    state_d = StIdle;
                end else if (mode_q) begin
                    // Fixed mode never leaves the dwell; only scan mode counts samples.
                    if (dwell_cnt_q == '0) begin
                        dwell_cnt_d = dwell_q;
                        state_d     = StSwitch;
                        if (sel_q != last_q) begin
                            sel_d = sel_q + 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (cont_q) begin
                                sel_d = first_q;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            guard_cnt_q <= '0;
            dwell_cnt_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            mode_q      <= 1'b0;
            cont_q      <= 1'b0;
            first_q     <= '0;
            last_q      <= '0;
            dwell_q     <= '0;
            keep_q      <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            guard_cnt_q <= guard_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            mode_q      <= mode_d;
            cont_q      <= cont_d;
            first_q     <= first_d;
            last_q      <= last_d;
            dwell_q     <= dwell_d;
            // An abort wipes every in-flight keep bit so nothing strobes after it.
            keep_q[0]   <= (state_q == StDwell) && !abort_go;
            tag_q[0]    <= sel_q;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                keep_q[i] <= keep_q[i-1] && !abort_go;
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign bus.mux_enable_o = (state_q != StIdle);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.mux_select_o = sel_q;
    assign bus.done_o       = done_q;
    assign bus.cfg_err_o    = cfg_err_q;
    assign bus.strobe_o     = bus.mux_valid_i && keep_q[LATENCY-1];
    assign bus.tag_o        = tag_q[LATENCY-1];
endmodule

// File: tb/tb_source_scanner.sv
// tb_source_scanner: directed and randomized runs of source_scanner checked cycle by cycle
// against a timeline model computed from source ranges, guard/dwell lengths and latency.
module tb_source_scanner;
    localparam int WIDTH   = 24;
    localparam int SBITS   = 5;
    localparam int CBITS   = 8;
    localparam int GUARD   = 2;
    localparam int LATENCY = 2;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   tests   = 0;
    int   fails   = 0;

    source_scanner_if #(.SBITS(SBITS), .CBITS(CBITS)) bus ();

    source_scanner #(
        .WIDTH(WIDTH), .SBITS(SBITS), .CBITS(CBITS), .GUARD(GUARD), .LATENCY(LATENCY)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timeline model: cycle i counts from the first cycle after the accepted start.
    // Each scanned source occupies GUARD discarded cycles followed by dwell+1 kept cycles.
    task automatic phase(input bit mode, input bit cont, input int fx, input int first,
                         input int last, input int dwell, input int i,
                         output bit live, output bit keep, output int sel);
        int per, s, j;
        per = GUARD + dwell + 1;
        s   = (last - first + 1) * per;
        if (!mode) begin
            live = 1'b1;
            keep = (i >= GUARD);
            sel  = fx;
        end else begin
            live = cont || (i < s);
            j    = i % s;
            keep = live && ((j % per) >= GUARD);
            sel  = first + j / per;
        end
    endtask

    task automatic run(input bit mode, input bit cont, input int fx, input int first,
                       input int last, input int dwell, input int ncyc, input int abort_at,
                       input bit rand_valid, input bit poke);
        bit aborted, live, keep, live_d, keep_d, busy_e, st_e;
        int sel, sel_d, s;
        s = (last - first + 1) * (GUARD + dwell + 1);
        @(negedge clock_i);
        bus.mode_i      = mode;
        bus.cont_i      = cont;
        bus.fixed_i     = SBITS'(fx);
        bus.first_i     = SBITS'(first);
        bus.last_i      = SBITS'(last);
        bus.dwell_i     = CBITS'(dwell);
        bus.start_i     = 1'b1;
        bus.abort_i     = 1'b0;
        bus.mux_valid_i = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock_i);
            // Config scrambled mid-run must have no effect.
            bus.start_i = poke && (i == 1);
            bus.first_i = SBITS'($urandom_range(0, 31));
            bus.dwell_i = CBITS'($urandom_range(0, 255));
            phase(mode, cont, fx, first, last, dwell, i, live, keep, sel);
            busy_e = live && !aborted;
            chk("busy", bus.busy_o, busy_e);
            chk("enable", bus.mux_enable_o, busy_e);
            if (busy_e) chk("select", bus.mux_select_o, sel);
            chk("done", bus.done_o,
                !aborted && mode && (i > 0) && (i % s == 0) && (cont || i == s));
            chk("cfg_err_run", bus.cfg_err_o, 0);
            st_e  = 1'b0;
            sel_d = 0;
            if (i >= LATENCY && !aborted) begin
                phase(mode, cont, fx, first, last, dwell, i - LATENCY, live_d, keep_d, sel_d);
                st_e = bus.mux_valid_i && keep_d;
            end
            chk("strobe", bus.strobe_o, st_e);
            if (st_e) chk("tag", bus.tag_o, sel_d);
            if (i == abort_at && busy_e) aborted = 1'b1;
            bus.abort_i     = (i == abort_at);
            bus.mux_valid_i = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        bus.start_i = 1'b0;
        bus.abort_i = 1'b1;
        @(negedge clock_i);
        bus.abort_i = 1'b0;
        repeat (LATENCY) @(negedge clock_i);
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_strobe", bus.strobe_o, 0);
    endtask

    task automatic try_start(input bit mode, input int fx, input int first, input int last,
                             input bit ab, input bit exp_err);
        @(negedge clock_i);
        bus.mode_i  = mode;
        bus.cont_i  = 1'b0;
        bus.fixed_i = SBITS'(fx);
        bus.first_i = SBITS'(first);
        bus.last_i  = SBITS'(last);
        bus.dwell_i = 8'd1;
        bus.start_i = 1'b1;
        bus.abort_i = ab;
        @(negedge clock_i);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("rej_busy", bus.busy_o, 0);
        chk("rej_enable", bus.mux_enable_o, 0);
        chk("cfg_err", bus.cfg_err_o, exp_err);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.mode_i      = 1'b0;
        bus.cont_i      = 1'b0;
        bus.fixed_i     = '0;
        bus.first_i     = '0;
        bus.last_i      = '0;
        bus.dwell_i     = '0;
        bus.mux_valid_i = 1'b1;

        // Reset values
        @(negedge clock_i);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_enable", bus.mux_enable_o, 0);
        chk("rst_select", bus.mux_select_o, 0);
        chk("rst_strobe", bus.strobe_o, 0);
        chk("rst_tag", bus.tag_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_cfg_err", bus.cfg_err_o, 0);
        reset_i = 1'b0;
        repeat (2) @(negedge clock_i);

        // Single sweep 3..5, dwell 3
        run(1'b1, 1'b0, 0, 3, 5, 3, 18 + LATENCY + 3, -1, 1'b0, 1'b0);
        // Continuous wrap 22..23, dwell 0, with a start poke while busy
        run(1'b1, 1'b1, 0, 22, 23, 0, 40, 38, 1'b0, 1'b1);
        // Fixed source 7 until abort
        run(1'b0, 1'b0, 7, 0, 0, 9, 30, 25, 1'b0, 1'b1);
        // Abort on the second dwell sample of source 1 in a 0..4 scan
        run(1'b1, 1'b0, 0, 0, 4, 3, 20, 9, 1'b0, 1'b0);

        // Bad configurations, abort-beats-start, then recovery
        try_start(1'b1, 0, 6, 2, 1'b0, 1'b1);
        try_start(1'b1, 0, 0, 24, 1'b0, 1'b1);
        try_start(1'b0, 24, 0, 0, 1'b0, 1'b1);
        try_start(1'b1, 0, 1, 2, 1'b1, 1'b1);
        run(1'b1, 1'b0, 0, 1, 2, 1, 12 + LATENCY + 3, -1, 1'b1, 1'b0);

        // Asynchronous reset during the guard of a fresh run
        @(negedge clock_i);
        bus.mode_i  = 1'b1;
        bus.cont_i  = 1'b1;
        bus.first_i = 5'd10;
        bus.last_i  = 5'd12;
        bus.dwell_i = 8'd1;
        bus.start_i = 1'b1;
        @(negedge clock_i);
        bus.start_i = 1'b0;
        chk("pre_rst_busy", bus.busy_o, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_enable", bus.mux_enable_o, 0);
        chk("arst_select", bus.mux_select_o, 0);
        chk("arst_done", bus.done_o, 0);
        chk("arst_strobe", bus.strobe_o, 0);
        @(negedge clock_i);
        reset_i = 1'b0;
        run(1'b1, 1'b0, 0, 10, 12, 1, 15 + LATENCY + 3, -1, 1'b1, 1'b0);

        // Randomized runs
        for (int k = 0; k < 10; k++) begin
            int f, l, d, n, ab, s;
            bit m, c;
            m  = ($urandom_range(0, 3) != 0);
            c  = 1'($urandom_range(0, 1));
            f  = $urandom_range(0, WIDTH - 1);
            l  = $urandom_range(f, (f + 3 > WIDTH - 1) ? WIDTH - 1 : f + 3);
            d  = $urandom_range(0, 4);
            s  = (l - f + 1) * (GUARD + d + 1);
            n  = (m && !c) ? s + LATENCY + 3 : $urandom_range(20, 50);
            ab = ($urandom_range(0, 1) != 0) ? $urandom_range(0, n - 2) : -1;
            run(m, c, f, f, l, d, n, ab, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
